// File: rtl/wb_queue.sv
// Write-back queue: buffers {addr, data} results from execute and drains one per
// cycle into the storage cells as a registered word plus a one-hot strobe.
module wb_queue #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4,
  parameter int NCELL = 8,
  localparam int AW = $clog2(NCELL),
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AW-1:0]    in_addr,
  output logic             in_ready,
  input  logic             hold,
  output logic [WIDTH-1:0] wd,
  output logic [NCELL-1:0] ws,
  output logic [NCELL-1:0] pend_mask,
  output logic [CW-1:0]    count
);

  logic [AW-1:0]    mem_addr [DEPTH];
  logic [WIDTH-1:0] mem_data [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             push;
  logic             pop;
  logic [PW-1:0]    idx;

  // Ready depends only on registered count, never on a same-edge pop.
  assign in_ready = (count != CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (count != '0) && !hold;

  // Entry storage needs no reset: only entries inside [rptr, rptr+count) are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wptr] <= in_addr;
      mem_data[wptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ws    <= '0;
      wd    <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) begin
        rptr <= rptr + 1'b1;
        wd   <= mem_data[rptr];
        ws   <= NCELL'(1) << mem_addr[rptr];
      end else begin
        ws <= '0;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    pend_mask = ws;
    idx       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rptr + PW'(i);
      if (CW'(i) < count) pend_mask = pend_mask | (NCELL'(1) << mem_addr[idx]);
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue: a queue-based reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_wb_queue;
  localparam int WIDTH = 17;
  localparam int DEPTH = 4;
  localparam int NCELL = 8;

  typedef struct {
    logic [2:0]       addr;
    logic [WIDTH-1:0] data;
  } entry_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic [2:0]       in_addr = '0;
  logic             in_ready;
  logic             hold = 1'b0;
  logic [WIDTH-1:0] wd;
  logic [NCELL-1:0] ws;
  logic [NCELL-1:0] pend_mask;
  logic [2:0]       count;

  int passed = 0;
  int total  = 0;

  entry_t           q[$];
  logic [NCELL-1:0] m_ws = '0;
  logic [WIDTH-1:0] m_wd = '0;

  wb_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NCELL(NCELL)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_addr(in_addr), .in_ready(in_ready), .hold(hold), .wd(wd), .ws(ws),
    .pend_mask(pend_mask), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: pop decision uses the pre-edge queue, then push if not full.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_ws = '0;
      m_wd = '0;
    end else begin
      bit do_push;
      do_push = in_valid && (q.size() != DEPTH);
      if (q.size() != 0 && !hold) begin
        m_wd = q[0].data;
        m_ws = '0;
        m_ws[q[0].addr] = 1'b1;
        void'(q.pop_front());
      end else begin
        m_ws = '0;
      end
      if (do_push) q.push_back('{addr: in_addr, data: in_data});
    end
  end

  always @(negedge clk) begin
    logic [NCELL-1:0] m_pend;
    m_pend = m_ws;
    foreach (q[i]) m_pend[q[i].addr] = 1'b1;
    check("ws", 32'(ws), 32'(m_ws));
    check("wd", 32'(wd), 32'(m_wd));
    check("pend_mask", 32'(pend_mask), 32'(m_pend));
    check("count", 32'(count), 32'(q.size()));
    check("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] a, input logic [WIDTH-1:0] d);
    in_valid = v;
    in_addr  = a;
    in_data  = d;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ws"}, 32'(ws), 0);
    check({tag, "_wd"}, 32'(wd), 0);
    check({tag, "_pend"}, 32'(pend_mask), 0);
    check({tag, "_count"}, 32'(count), 0);
    check({tag, "_ready"}, 32'(in_ready), 1);
  endtask

  initial begin
    #1;
    check_reset_state("rst0");
    step();
    rst_n = 1'b1;
    step();

    // Single write: data 20 to cell 3
    drive(1, 3'd3, 17'd20);
    step();
    drive(0, 0, 0);
    check("single_pend_after_accept", 32'(pend_mask), 32'h08);
    check("single_ws_after_accept", 32'(ws), 0);
    step();
    check("single_ws", 32'(ws), 32'h08);
    check("single_wd", 32'(wd), 20);
    check("single_pend_during", 32'(pend_mask), 32'h08);
    step();
    check("single_ws_end", 32'(ws), 0);
    check("single_pend_end", 32'(pend_mask), 0);

    // Fill under hold, attempt fifth push, then drain
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1, 3'(i), 17'(i + 1));
      step();
    end
    check("full_count", 32'(count), 4);
    check("full_ready", 32'(in_ready), 0);
    drive(1, 3'd7, 17'd9);
    step();
    check("full_reject_count", 32'(count), 4);
    check("full_reject_pend", 32'(pend_mask), 32'h0F);
    drive(0, 0, 0);
    hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("drain_ws", 32'(ws), 32'(1 << i));
      check("drain_wd", 32'(wd), 32'(i + 1));
    end
    step();
    check("drain_idle", 32'(ws), 0);

    // Simultaneous push and pop at count = 2
    hold = 1'b1;
    drive(1, 3'd1, 17'd10); step();
    drive(1, 3'd2, 17'd11); step();
    hold = 1'b0;
    drive(1, 3'd4, 17'd12); step();
    check("simul_count_a", 32'(count), 2);
    check("simul_ws_a", 32'(ws), 32'h02);
    check("simul_wd_a", 32'(wd), 10);
    drive(1, 3'd6, 17'd13); step();
    check("simul_count_b", 32'(count), 2);
    check("simul_wd_b", 32'(wd), 11);
    drive(0, 0, 0); step();
    check("simul_wd_c", 32'(wd), 12);
    step();
    check("simul_ws_d", 32'(ws), 32'h40);
    check("simul_wd_d", 32'(wd), 13);
    step();

    // Same-address ordering on cell 5
    drive(1, 3'd5, 17'd20); step();
    check("same_pend_a", 32'(pend_mask), 32'h20);
    drive(1, 3'd5, 17'd35); step();
    check("same_ws_a", 32'(ws), 32'h20);
    check("same_wd_a", 32'(wd), 20);
    check("same_pend_b", 32'(pend_mask), 32'h20);
    drive(0, 0, 0); step();
    check("same_ws_b", 32'(ws), 32'h20);
    check("same_wd_b", 32'(wd), 35);
    check("same_pend_c", 32'(pend_mask), 32'h20);
    step();
    check("same_pend_end", 32'(pend_mask), 0);

    // Hold mid-drain
    hold = 1'b1;
    drive(1, 3'd0, 17'd5); step();
    drive(1, 3'd7, 17'd6); step();
    drive(1, 3'd2, 17'd7); step();
    drive(0, 0, 0);
    hold = 1'b0; step();
    check("hold_first_ws", 32'(ws), 32'h01);
    hold = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("hold_ws_low", 32'(ws), 0);
      check("hold_pend", 32'(pend_mask), 32'h84);
    end
    hold = 1'b0; step();
    check("hold_ws_b", 32'(ws), 32'h80);
    check("hold_wd_b", 32'(wd), 6);
    step();
    check("hold_wd_c", 32'(wd), 7);
    step();

    // Reset mid-operation: 3 queued and a strobe active
    hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1, 3'(i), 17'(i)); step();
    end
    drive(0, 0, 0);
    hold = 1'b0; step();
    check("pre_rst_ws", 32'(ws), 32'h02);
    check("pre_rst_count", 32'(count), 3);
    #2 rst_n = 1'b0;
    #1 check_reset_state("rst_mid");
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_rst_ws", 32'(ws), 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/wb_queue.md
# wb_queue

Write-back queue that sits directly upstream of the bank of 17-bit single-entry storage cells in the 6-bit CPU datapath. It accepts results from the execute stage over a valid/ready handshake and buffers them in a small FIFO. It then drains one entry per cycle into the cells as a registered data word plus a one-hot write strobe. It also publishes a per-cell pending mask so the operand-fetch logic can stall on read-after-write hazards.

## Interface
Parameters:
- WIDTH, 17, data word width (matches storage cell width)
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- NCELL, 8, number of storage cells; cell address width AW = log2(NCELL)

Ports:
- clk  input  1  rising-edge clock; the only clock in the block
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  execute stage presents a result
- in_data  input  WIDTH  result word
- in_addr  input  AW  destination cell index
- in_ready  output  1  queue can accept; = (count != DEPTH), combinational from state only
- hold  input  1  downstream stall; no pop while high
- wd  output  WIDTH  registered write data to cells
- ws  output  NCELL  registered one-hot write strobe to cells; at most one bit high
- pend_mask  output  NCELL  bit i high if any queued entry or the strobe currently on ws targets cell i
- count  output  log2(DEPTH)+1  current number of queued entries

## Operation
- Storage: DEPTH entries of {addr, data}; write pointer, read pointer, and count. Pointers wrap modulo DEPTH.
- Push: at a rising edge with in_valid && in_ready, write {in_addr, in_data} at wptr, wptr+1, count+1.
- Pop: at a rising edge with count != 0 && !hold, load the head into the output registers: wd <= head data, ws <= one-hot(head addr); then rptr+1, count-1.
- Otherwise, ws <= 0 at that edge; wd holds its last value. ws is therefore a single-cycle pulse per popped entry.
- Simultaneous push and pop at the same edge: both occur; count is unchanged.
- Full: in_ready = 0, so no push is possible, even if a pop occurs on the same edge. There is no combinational ready-from-pop path.
- Empty: no pop; ws <= 0. A word pushed into an empty queue cannot pop on the same edge it is written.
- Same-address entries drain in FIFO order; there is no merging or reordering.
- pend_mask is combinational: the OR over valid queue entries of one-hot(addr), ORed with the current ws.
- Asynchronous reset (rst_n low) clears:
  - pointers and count to 0, so queued entries are discarded;
  - ws = 0, wd = 0, pend_mask = 0, count = 0, in_ready = 1.
- Deassertion of rst_n is assumed synchronous to clk externally.
- Behaviour for in_addr ≥ NCELL is undefined; the driver must not issue it.

## Timing
- Latency: a word accepted at edge N is on ws/wd after edge N+1 when the queue was empty and hold is low. The cell captures it at edge N+2.
- Throughput: one push and one pop per cycle sustained.
- pend_mask bit rises in the cycle after the accepting edge. It falls after the edge at which the corresponding ws pulse ends, unless another entry targets the same cell.
- hold sampled high at edge E: no pop at E, ws low after E. The head entry stays queued and pend_mask is unchanged for it.
- count/in_ready update only at clock edges, or asynchronously on reset.

## Test plan
- Reset then single write:
  - Assert rst_n low mid-cycle: all outputs 0, in_ready = 1, immediately.
  - Push data 20 to addr 3: ws = 8'b0000_1000 and wd = 20 for exactly one cycle, one edge after acceptance.
  - pend_mask[3] is high from acceptance until the ws pulse ends.
- Fill and full:
  - With hold = 1, push 4 words (addr 0..3, data 1..4): count = 4, in_ready = 0.
  - A fifth push with in_valid = 1 is not accepted.
  - Release hold: ws pulses cells 0, 1, 2, 3 on four consecutive cycles with wd 1..4.
- Simultaneous push and pop at count = 2: count stays 2, and output order is preserved.
- Same-address ordering:
  - Push data 20 then 35 to addr 5: two consecutive ws[5] pulses with wd 20 then 35.
  - pend_mask[5] stays high continuously until the second pulse ends.
- Hold mid-drain:
  - With 3 queued entries, assert hold for 2 cycles after the first pop: ws low for those 2 cycles.
  - Remaining entries then drain in order.
- Reset mid-operation: assert rst_n low with 3 queued and ws active. ws, count, and pend_mask clear immediately, and no further strobes occur after release.
